// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store alignment unit.
package lsu_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SECOND = 1'b1
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/lsu_extract.sv
// Load extraction: shifts a 128-bit window down by the byte offset, then sign/zero extends.
module lsu_extract
  import lsu_pkg::*;
(
  input  logic [127:0] data_i,
  input  logic [2:0]   off_i,
  input  logic [2:0]   funct3_i,
  output logic [63:0]  result_o
);

  logic [127:0] shifted;

  assign shifted = data_i >> {off_i, 3'b000};

  always_comb begin
    result_o = '0;
    case (funct3_i)
      F3_B:    result_o = {{56{shifted[7]}},  shifted[7:0]};
      F3_H:    result_o = {{48{shifted[15]}}, shifted[15:0]};
      F3_W:    result_o = {{32{shifted[31]}}, shifted[31:0]};
      F3_D:    result_o = shifted[63:0];
      F3_BU:   result_o = {56'd0, shifted[7:0]};
      F3_HU:   result_o = {48'd0, shifted[15:0]};
      F3_WU:   result_o = {32'd0, shifted[31:0]};
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit: doubleword RMW stores, extended loads, two-cycle straddle split.
// Optional macro LSU_MISALIGN_TRAP_EN adds a misalign output and suppresses misaligned accesses.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int DW_BYTES = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_read,
  input  logic            req_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_a,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd,
  output logic [XLEN-1:0] rdata,
`ifdef LSU_MISALIGN_TRAP_EN
  output logic            misalign,
`endif
  output logic            stall
);

  localparam int OFFW = $clog2(DW_BYTES);

  lsu_state_e      state_q, state_d;
  logic [XLEN-1:0] lo_buf_q, lo_buf_d;
  logic [XLEN-1:0] mem_a_hi_q, mem_a_hi_d;

  logic [OFFW-1:0] off;
  logic [3:0]      size;
  logic [2:0]      amask;
  logic            req_any, is_store, straddle, trap, active, we;
  logic [XLEN-1:0] base;
  logic [15:0]     bmask;
  logic [127:0]    wsh;
  logic [63:0]     wd_lo, wd_hi, ext_res;
  logic [127:0]    ext_data;

  assign off      = addr[OFFW-1:0];
  assign size     = size_bytes(funct3);
  assign amask    = size[2:0] - 3'd1;
  assign req_any  = (req_read || req_write) && (funct3 != 3'b111);
  assign is_store = req_write;
  assign straddle = req_any && (({1'b0, off} + size) > 4'd8);
  assign base     = {addr[XLEN-1:OFFW], {OFFW{1'b0}}};

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap     = req_any && ((off & amask) != 3'd0);
  assign misalign = trap;
`else
  assign trap     = 1'b0;
`endif

  assign active = req_any && !trap;

  // Byte-enable mask and data positioned across the two-doubleword window.
  assign bmask = ((16'd1 << size) - 16'd1) << off;
  assign wsh   = {64'd0, wdata} << {off, 3'b000};

  always_comb begin
    for (int b = 0; b < 8; b++) begin
      wd_lo[b*8 +: 8] = bmask[b]     ? wsh[b*8 +: 8]      : mem_rd[b*8 +: 8];
      wd_hi[b*8 +: 8] = bmask[8 + b] ? wsh[64 + b*8 +: 8] : mem_rd[b*8 +: 8];
    end
  end

  assign ext_data = (state_q == SECOND) ? {mem_rd, lo_buf_q} : {64'd0, mem_rd};

  lsu_extract u_extract (
    .data_i   (ext_data),
    .off_i    (off),
    .funct3_i (funct3),
    .result_o (ext_res)
  );

  always_comb begin
    state_d    = state_q;
    lo_buf_d   = lo_buf_q;
    mem_a_hi_d = mem_a_hi_q;
    mem_a      = base;
    mem_wd     = wd_lo;
    we         = 1'b0;
    rdata      = '0;
    stall      = 1'b0;
    case (state_q)
      IDLE: begin
        if (active) begin
          if (is_store) begin
            we = 1'b1;
          end else if (!straddle) begin
            rdata = ext_res;
          end
          if (straddle) begin
            stall      = 1'b1;
            mem_a_hi_d = base + 64'd8;
            state_d    = SECOND;
            if (!is_store) lo_buf_d = mem_rd;
          end
        end
      end
      SECOND: begin
        mem_a   = mem_a_hi_q;
        mem_wd  = wd_hi;
        state_d = IDLE;
        if (active) begin
          if (is_store) we = 1'b1;
          else          rdata = ext_res;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset must block writes immediately, including an in-flight second half.
  assign mem_we = we && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lo_buf_q   <= '0;
      mem_a_hi_q <= '0;
    end else begin
      state_q    <= state_d;
      lo_buf_q   <= lo_buf_d;
      mem_a_hi_q <= mem_a_hi_d;
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
// Scoreboard bench for lsu_align: byte-level memory model, randomized and directed accesses.
module tb_lsu_align;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_read = 1'b0, req_write = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [63:0] addr = '0, wdata = '0;
  logic        mem_we;
  logic [63:0] mem_a, mem_wd, mem_rd, rdata;
  logic        stall;
`ifdef LSU_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  lsu_align dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_read  (req_read),
    .req_write (req_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .mem_we    (mem_we),
    .mem_a     (mem_a),
    .mem_wd    (mem_wd),
    .mem_rd    (mem_rd),
    .rdata     (rdata),
`ifdef LSU_MISALIGN_TRAP_EN
    .misalign  (misalign),
`endif
    .stall     (stall)
  );

  always #5 clk = ~clk;

  logic [63:0] mem [0:1023];
  assign mem_rd = mem[mem_a[12:3]];
  always @(posedge clk) if (mem_we) mem[mem_a[12:3]] <= mem_wd;

  logic [7:0] ref_mem [0:8191];
  typedef struct { logic [63:0] a; logic [63:0] d; } wr_t;
  logic [63:0] rq[$];
  wr_t         wq[$];
  int n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_dw(input logic [63:0] a);
    logic [63:0] r;
    logic [63:0] b;
    b = a & ~64'd7;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = ref_mem[int'(b[12:0]) + i];
    return r;
  endfunction

  task automatic set_dw(input int idx, input logic [63:0] v);
    mem[idx] = v;
    for (int i = 0; i < 8; i++) ref_mem[idx*8 + i] = v[i*8 +: 8];
  endtask

  // Reference: operate on bytes, then report the doubleword images the memory should receive.
  task automatic model_issue(input bit rd, input bit wr, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] wd, input bit low_only,
                             output int cyc, output bit mis);
    int size, off;
    bit valid, strad;
    logic [63:0] v, base, ba;
    wr_t w;
    valid = (rd || wr) && (f3 != 3'b111);
    size  = 1 << f3[1:0];
    off   = int'(a[2:0]);
    strad = (off + size) > 8;
    mis   = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis   = valid && ((off % size) != 0);
`endif
    cyc = 1;
    if (!valid) return;
    if (mis) begin
      if (!wr) rq.push_back(64'd0);
      return;
    end
    if (strad) cyc = 2;
    base = a & ~64'd7;
    if (wr) begin
      for (int i = 0; i < size; i++) begin
        if (!(low_only && (off + i) >= 8)) begin
          ba = a + 64'(i);
          ref_mem[int'(ba[12:0])] = wd[i*8 +: 8];
        end
      end
      w.a = base; w.d = ref_dw(base); wq.push_back(w);
      if (strad && !low_only) begin
        w.a = base + 64'd8; w.d = ref_dw(base + 64'd8); wq.push_back(w);
      end
    end else begin
      v = '0;
      for (int i = 0; i < size; i++) begin
        ba = a + 64'(i);
        v[i*8 +: 8] = ref_mem[int'(ba[12:0])];
      end
      if (!f3[2] && v[size*8-1]) for (int i = size*8; i < 64; i++) v[i] = 1'b1;
      rq.push_back(v);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: addr 0x%016h data 0x%016h", mem_a, mem_wd);
        end else begin
          wr_t w;
          w = wq.pop_front();
          check("write_addr", mem_a, w.a);
          check("write_data", mem_wd, w.d);
        end
      end
      if (req_read && !req_write && funct3 != 3'b111 && !stall) begin
        if (rq.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_load: rdata 0x%016h expected none", rdata);
        end else begin
          check("load_rdata", rdata, rq.pop_front());
        end
      end else begin
        check("rdata_zero", rdata, 64'd0);
      end
    end
  end

  task automatic idle_inputs();
    req_read = 1'b0; req_write = 1'b0; funct3 = 3'b0; addr = '0; wdata = '0;
  endtask

  task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd);
    int cyc, seen;
    bit mis, done;
    logic [63:0] base;
    req_read = rd; req_write = wr; funct3 = f3; addr = a; wdata = wd;
    model_issue(rd, wr, f3, a, wd, 1'b0, cyc, mis);
    base = a & ~64'd7;
    seen = 0; done = 0;
    while (!done && seen < 4) begin
      @(negedge clk);
      seen++;
      if ((rd || wr) && f3 != 3'b111)
        check("mem_a", mem_a, (seen == 1) ? base : base + 64'd8);
`ifdef LSU_MISALIGN_TRAP_EN
      if (seen == 1) check("misalign", 64'(misalign), 64'(mis));
`endif
      if (!stall) done = 1;
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL access_timeout: stall still 1 after %0d cycles, expected 0", seen);
    end
    check("access_cycles", 64'(seen), 64'(cyc));
    @(posedge clk); #1;
    idle_inputs();
  endtask

  initial begin
    int errs, cyc;
    bit mis;
    logic [63:0] v, a;
    for (int i = 0; i < 1024; i++) set_dw(i, {$urandom, $urandom});

    #1;
    check("reset_mem_we", 64'(mem_we), 64'd0);
    check("reset_stall", 64'(stall), 64'd0);
    check("reset_rdata", rdata, 64'd0);
    req_write = 1'b1; funct3 = 3'b011; wdata = 64'hDEAD_BEEF_0000_1111;
    #1;
    check("reset_forces_we_low", 64'(mem_we), 64'd0);
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    set_dw(2, 64'h8877_6655_4433_2211);
    access(1, 0, 3'b011, 64'h10, 0);
    set_dw(2, 64'h80FF_0000_0000_0000);
    access(1, 0, 3'b000, 64'h17, 0);
    access(1, 0, 3'b100, 64'h17, 0);
    set_dw(1, 64'd0);
    access(0, 1, 3'b001, 64'h0A, 64'hBEEF);
    check("sh_result", mem[1], 64'h0000_0000_BEEF_0000);
    set_dw(1, 64'hDDCC_0000_0000_0000);
    set_dw(2, 64'h0000_0000_0000_0403);
    access(1, 0, 3'b010, 64'h0E, 0);
    set_dw(1, 64'd0); set_dw(2, 64'd0);
    access(0, 1, 3'b011, 64'h0B, 64'h1122_3344_5566_7788);
    check("sd_hi_result", mem[2], 64'h0000_0000_0011_2233);
    check("sd_lo_result", mem[1], 64'h4455_6677_8800_0000);
    access(1, 1, 3'b010, 64'h1C, 64'hCAFE_F00D);
    access(1, 0, 3'b111, 64'h20, 0);
    access(1, 0, 3'b010, 64'hFFFF_FFFF_FFFF_FFFE, 0);
    access(0, 1, 3'b011, 64'hFFFF_FFFF_FFFF_FFF9, {$urandom, $urandom});

    // Abort a split store by reset while the second half is pending.
    set_dw(1, 64'd0); set_dw(2, 64'hA5A5_A5A5_A5A5_A5A5);
    req_write = 1'b1; funct3 = 3'b011; addr = 64'h0B; wdata = 64'h1122_3344_5566_7788;
    model_issue(0, 1, 3'b011, 64'h0B, wdata, 1'b1, cyc, mis);
    @(negedge clk);
    @(posedge clk); #1;
`ifndef LSU_MISALIGN_TRAP_EN
    check("second_mem_a", mem_a, 64'h10);
    check("second_we", 64'(mem_we), 64'd1);
`endif
    rst_n = 1'b0; #1;
    check("abort_we_low", 64'(mem_we), 64'd0);
    check("abort_idle_mem_a", mem_a, 64'h08);
    idle_inputs(); #1;
    check("abort_stall", 64'(stall), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_hi_unchanged", mem[2], 64'hA5A5_A5A5_A5A5_A5A5);

    for (int n = 0; n < 400; n++) begin
      int k;
      bit rd, wr;
      logic [2:0] f3;
      k  = $urandom_range(0, 7);
      rd = (k < 4) || (k == 7);
      wr = (k >= 4);
      f3 = rd && !wr ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a[63:13] = '0;
      access(rd, wr, f3, a, {$urandom, $urandom});
    end

    repeat (2) @(posedge clk);
    #1;
    check("queues_drained", 64'(rq.size() + wq.size()), 64'd0);
    errs = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_dw(64'(i * 8))) errs++;
    check("final_memory_image_errors", 64'(errs), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule
